// File: rtl/puf_nist_test_ctrl_if.sv
// Challenge/response and result-memory bundle of the PUF NIST test controller.
// master is the controller's view; slave is the PUF/NIST/memory environment.
interface puf_nist_test_ctrl_if #(
  parameter int N_CB   = 64,
  parameter int N_TEST = 8,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 13
);
  logic              start;
  logic              mode;
  logic [N_CB-1:0]   C;
  logic              response;
  logic [N_TEST-1:0] test_result;
  logic [N_CB-1:0]   challenge;
  logic              test_data;
  logic              test_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [CNT_W-1:0]  mem_din;
  logic              busy;
  logic              done;

  modport master (
    input  start, mode, C, response, test_result,
    output challenge, test_data, test_en, mem_we, mem_waddr, mem_din, busy, done
  );

  modport slave (
    output start, mode, C, response, test_result,
    input  challenge, test_data, test_en, mem_we, mem_waddr, mem_din, busy, done
  );
endinterface

// File: rtl/puf_nist_test_ctrl.sv
// PUF randomness-qualification controller: streams response bits to NIST, tallies passes per round, writes tallies.
// All outputs registered; no backpressure, test_en marks each bit the NIST block must consume that cycle.
module puf_nist_test_ctrl #(
  parameter int N_CB       = 64,
  parameter int N_TEST     = 8,
  parameter int CNT_W      = 8,
  parameter int ROUND_BITS = 20000,
  parameter int N_ROUNDS   = 255,
  parameter int ADDR_W     = 13,
  parameter int BASE_ADDR  = 0
) (
  input  logic                clk_1,
  input  logic                rst,
  puf_nist_test_ctrl_if.master bus
);
  localparam int BIT_W = (ROUND_BITS > 1) ? $clog2(ROUND_BITS) : 1;
  localparam int RND_W = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1;
  localparam int IDX_W = (N_TEST > 1) ? $clog2(N_TEST) : 1;

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_TALLY, S_STORE, S_DONE} state_t;
  state_t state, state_nxt;

  logic             mode_q, pair_q, hold;
  logic [BIT_W-1:0] bit_cnt;
  logic [RND_W-1:0] round_cnt;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] tally [N_TEST];

  logic start_ok, issue, last_bit, last_round, last_idx;
  logic en_nxt, we_nxt, busy_nxt, done_nxt;

  assign start_ok   = bus.start && (state == S_IDLE || state == S_DONE);
  // In pair mode only the second cycle of each pair produces a test bit.
  assign issue      = (state == S_COLLECT) && (!mode_q || pair_q);
  assign last_bit   = issue && (bit_cnt == BIT_W'(ROUND_BITS - 1));
  assign last_round = (round_cnt == RND_W'(N_ROUNDS - 1));
  assign last_idx   = (idx == IDX_W'(N_TEST - 1));

  always_ff @(posedge clk_1) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (bus.start) state_nxt = S_COLLECT;
      S_COLLECT:      if (last_bit) state_nxt = S_TALLY;
      S_TALLY:        state_nxt = last_round ? S_STORE : S_COLLECT;
      S_STORE:        if (last_idx) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    en_nxt   = issue;
    we_nxt   = (state == S_STORE);
    busy_nxt = (state_nxt == S_COLLECT) || (state_nxt == S_TALLY) || (state_nxt == S_STORE);
    done_nxt = (state_nxt == S_DONE);
  end

  always_ff @(posedge clk_1) begin
    if (rst) begin
      bus.challenge <= '0;
      bus.test_data <= 1'b0;
      bus.test_en   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_waddr <= ADDR_W'(BASE_ADDR);
      bus.mem_din   <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      mode_q        <= 1'b0;
      pair_q        <= 1'b0;
      hold          <= 1'b0;
      bit_cnt       <= '0;
      round_cnt     <= '0;
      idx           <= '0;
      for (int i = 0; i < N_TEST; i++) tally[i] <= '0;
    end else begin
      bus.challenge <= bus.C;
      bus.test_en   <= en_nxt;
      bus.mem_we    <= we_nxt;
      bus.busy      <= busy_nxt;
      bus.done      <= done_nxt;

      if (start_ok) begin
        mode_q    <= bus.mode;
        pair_q    <= 1'b0;
        bit_cnt   <= '0;
        round_cnt <= '0;
        for (int i = 0; i < N_TEST; i++) tally[i] <= '0;
      end

      if (state == S_COLLECT) begin
        if (mode_q && !pair_q) begin
          hold   <= bus.response;
          pair_q <= 1'b1;
        end else begin
          bus.test_data <= mode_q ? (hold ^ bus.response) : bus.response;
          pair_q        <= 1'b0;
          bit_cnt       <= last_bit ? '0 : bit_cnt + BIT_W'(1);
        end
      end

      if (state == S_TALLY) begin
        // Tallies stick at all-ones so a long run cannot wrap a passing test to zero.
        for (int i = 0; i < N_TEST; i++)
          if (tally[i] != '1) tally[i] <= tally[i] + CNT_W'(bus.test_result[i]);
        round_cnt <= round_cnt + RND_W'(1);
        if (last_round) idx <= '0;
        else            pair_q <= 1'b0;
      end

      if (state == S_STORE) begin
        bus.mem_waddr <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
        bus.mem_din   <= tally[idx];
        idx           <= idx + IDX_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_puf_nist_test_ctrl.sv
// Randomized scoreboard bench for puf_nist_test_ctrl; a second instance exercises tally saturation.
module tb_puf_nist_test_ctrl;
  localparam int NCB  = 64;
  localparam int NT   = 4;
  localparam int CW   = 8;
  localparam int RB   = 16;
  localparam int NR   = 3;
  localparam int AW   = 13;
  localparam int BASE = 5;
  localparam int NR_S = 5;
  localparam int CW_S = 2;

  logic           clk_1 = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           start_s = 1'b0;
  logic           mode = 1'b0;
  logic           response = 1'b0;
  logic [NCB-1:0] c_in = '0;
  logic [NT-1:0]  test_result = '0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } wr_t;

  wr_t exp_wr[$];
  bit  exp_bits[$];
  wr_t mon_w;

  puf_nist_test_ctrl_if #(.N_CB(NCB), .N_TEST(NT), .CNT_W(CW),   .ADDR_W(AW)) bus ();
  puf_nist_test_ctrl_if #(.N_CB(NCB), .N_TEST(NT), .CNT_W(CW_S), .ADDR_W(AW)) bus_s ();

  assign bus.start         = start;
  assign bus.mode          = mode;
  assign bus.C             = c_in;
  assign bus.response      = response;
  assign bus.test_result   = test_result;
  assign bus_s.start       = start_s;
  assign bus_s.mode        = mode;
  assign bus_s.C           = c_in;
  assign bus_s.response    = response;
  assign bus_s.test_result = test_result;

  puf_nist_test_ctrl #(
    .N_CB(NCB), .N_TEST(NT), .CNT_W(CW), .ROUND_BITS(RB), .N_ROUNDS(NR),
    .ADDR_W(AW), .BASE_ADDR(BASE)
  ) dut (
    .clk_1(clk_1), .rst(rst), .bus(bus.master)
  );

  puf_nist_test_ctrl #(
    .N_CB(NCB), .N_TEST(NT), .CNT_W(CW_S), .ROUND_BITS(RB), .N_ROUNDS(NR_S),
    .ADDR_W(AW), .BASE_ADDR(BASE)
  ) dut_s (
    .clk_1(clk_1), .rst(rst), .bus(bus_s.master)
  );

  always #5 clk_1 = ~clk_1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every DUT output event is matched against what the stimulus side predicted.
  always @(posedge clk_1) begin
    #1;
    chk("challenge", bus.challenge, rst ? 64'(0) : c_in);
    if (bus.test_en) begin
      if (exp_bits.size() == 0) chk("unexpected_test_en", 1, 0);
      else chk("test_data", bus.test_data, exp_bits.pop_front());
    end
    if (bus.mem_we) begin
      if (exp_wr.size() == 0) chk("unexpected_mem_we", 1, 0);
      else begin
        mon_w = exp_wr.pop_front();
        chk("mem_waddr", bus.mem_waddr, mon_w.addr);
        chk("mem_din", bus.mem_din, mon_w.data);
      end
    end
  end

  // One run seen from the start edge: edge 0 accepts start, then NR rounds of L edges, then NT stores.
  task automatic do_run(input bit m, input bit toggle, input bit tr_fix_en,
                        input logic [NT-1:0] tr_fix, input int mid_start, input bit abort);
    int L, run_len, t_end, pos, u;
    int tl[NT];
    bit hold;
    logic [NT-1:0] cur_tr;
    L       = m ? 2*RB + 1 : RB + 1;
    run_len = 1 + NR*L + NT;
    t_end   = abort ? NR*L + 2 : run_len - 1;
    for (int i = 0; i < NT; i++) tl[i] = 0;
    hold   = 1'b0;
    cur_tr = '0;
    for (int t = 0; t <= t_end; t++) begin
      @(negedge clk_1);
      if (t == 1) begin
        chk("busy_after_start", bus.busy, 1);
        chk("done_after_start", bus.done, 0);
      end
      if (t == run_len - 1) chk("done_before_end", bus.done, 0);
      start    = (t == 0) || (t == mid_start);
      mode     = (t == 0) ? m : 1'($urandom);
      c_in     = {$urandom, $urandom};
      response = toggle ? 1'(t % 2) : 1'($urandom);
      u = t - 1;
      if (t >= 1 && u < NR*L) begin
        pos = u % L;
        if (pos == 0) begin
          cur_tr      = tr_fix_en ? tr_fix : NT'($urandom);
          test_result = cur_tr;
        end
        if (pos < L - 1) begin
          if (!m) exp_bits.push_back(response);
          else if (pos % 2 == 0) hold = response;
          else exp_bits.push_back(hold ^ response);
        end else begin
          for (int i = 0; i < NT; i++)
            if (cur_tr[i] && tl[i] < (1 << CW) - 1) tl[i]++;
        end
      end
      if (t >= 1 && u == NR*L)
        for (int i = 0; i < NT; i++)
          if (!abort || i < 2) exp_wr.push_back('{addr: AW'(BASE + i), data: CW'(tl[i])});
    end
    if (abort) begin
      @(negedge clk_1);
      rst   = 1'b1;
      start = 1'b0;
      c_in  = {$urandom, $urandom};
      @(negedge clk_1);
      chk("abort_mem_we", bus.mem_we, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_test_en", bus.test_en, 0);
      chk("abort_waddr", bus.mem_waddr, AW'(BASE));
      rst = 1'b0;
    end else begin
      @(negedge clk_1);
      chk("done_at_end", bus.done, 1);
      chk("busy_at_end", bus.busy, 0);
    end
    start = 1'b0;
    chk("bits_drained", exp_bits.size(), 0);
    chk("writes_drained", exp_wr.size(), 0);
  endtask

  task automatic sat_run();
    int nw;
    int len;
    nw  = 0;
    len = 1 + NR_S*(RB + 1) + NT;
    for (int t = 0; t < len; t++) begin
      @(negedge clk_1);
      start_s     = (t == 0);
      mode        = (t == 0) ? 1'b0 : 1'($urandom);
      c_in        = {$urandom, $urandom};
      response    = 1'($urandom);
      test_result = '1;
      @(posedge clk_1);
      #1;
      if (bus_s.mem_we) begin
        chk("sat_waddr", bus_s.mem_waddr, AW'(BASE + nw));
        chk("sat_din", bus_s.mem_din, 3);
        nw++;
      end
    end
    start_s = 1'b0;
    chk("sat_writes", nw, NT);
    chk("sat_done", bus_s.done, 1);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_1);
      start       = 1'($urandom);
      mode        = 1'($urandom);
      c_in        = {$urandom, $urandom};
      response    = 1'($urandom);
      test_result = NT'($urandom);
      @(posedge clk_1);
      #1;
      chk("rst_test_en", bus.test_en, 0);
      chk("rst_test_data", bus.test_data, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_waddr", bus.mem_waddr, AW'(BASE));
      chk("rst_mem_din", bus.mem_din, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
    end
    @(negedge clk_1);
    rst   = 1'b0;
    start = 1'b0;

    do_run(1'b0, 1'b0, 1'b1, 4'b0101, -1, 1'b0);
    do_run(1'b1, 1'b1, 1'b0, '0, -1, 1'b0);
    do_run(1'b0, 1'b0, 1'b0, '0, 20, 1'b0);
    do_run(1'b1, 1'b0, 1'b0, '0, -1, 1'b1);
    do_run(1'b0, 1'b0, 1'b0, '0, -1, 1'b0);
    do_run(1'b1, 1'b0, 1'b0, '0, 40, 1'b0);
    sat_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
